// File: rtl/mmio_interconnect_pkg.sv
// Shared state encoding and default constants for the MMIO interconnect.
// Imported by mmio_addr_decode and mmio_interconnect.
package mmio_interconnect_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEADBEEF;
  localparam int          DEFAULT_TIMEOUT  = 16;

  // Width of the slave index field taken from the CPU address.
  localparam int          IDX_W            = 4;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational slave decode: 4-bit region index -> one-hot select plus
// an out-of-range flag for indices with no slave behind them.
module mmio_addr_decode
  import mmio_interconnect_pkg::*;
#(
  parameter int NUM_SLAVES = 4
) (
  input  logic [IDX_W-1:0]      index_field,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  range_err
);

  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel[i] = (index_field == IDX_W'(i));
    end
  end

  assign range_err = ({1'b0, index_field} >= (IDX_W + 1)'(NUM_SLAVES));

endmodule

// File: rtl/mmio_interconnect.sv
// CPU data port to NUM_SLAVES memory-mapped slaves: decode, handshake, read return, timeout.
// Optional error log (err_addr, err_count) is built when MMIO_ERR_LOG_EN is defined.
module mmio_interconnect
  import mmio_interconnect_pkg::*;
#(
  parameter int                NUM_SLAVES  = 4,
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                WE_W        = 4,
  parameter int                REGION_BITS = 12,
  parameter int                TIMEOUT     = DEFAULT_TIMEOUT,
  parameter logic [DATA_W-1:0] ERR_DATA    = DATA_W'(DEFAULT_ERR_DATA)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_valid,
  input  logic [ADDR_W-1:0]            cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic [WE_W-1:0]              cpu_we,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_ready,
  output logic                         cpu_err,
  output logic [NUM_SLAVES-1:0]        per_ce,
  output logic [ADDR_W-1:0]            per_addr,
  output logic [DATA_W-1:0]            per_wdata,
  output logic [WE_W-1:0]              per_we,
  input  logic [NUM_SLAVES*DATA_W-1:0] per_rdata,
  input  logic [NUM_SLAVES-1:0]        per_ready
`ifdef MMIO_ERR_LOG_EN
  ,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [7:0]                   err_count
`endif
);

  localparam int CNT_W = $clog2(TIMEOUT);

  state_t                  state;
  state_t                  state_next;
  logic [ADDR_W-1:0]       addr_q;
  logic [DATA_W-1:0]       wdata_q;
  logic [WE_W-1:0]         we_q;
  logic [NUM_SLAVES-1:0]   sel_q;
  logic                    err_q;
  logic [CNT_W-1:0]        cnt;

  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_err;
  logic                    sel_ready;
  logic [DATA_W-1:0]       sel_rdata;
  logic                    accept;
  logic                    done_ok;
  logic                    timed_out;

  mmio_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES)
  ) u_decode (
    .index_field (cpu_addr[REGION_BITS+IDX_W-1:REGION_BITS]),
    .sel         (dec_sel),
    .range_err   (dec_err)
  );

  // Only the latched slave's ready and read data are ever looked at.
  assign sel_ready = |(per_ready & sel_q);

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) sel_rdata = sel_rdata | per_rdata[i*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    done_ok    = 1'b0;
    timed_out  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cpu_valid) begin
          accept     = 1'b1;
          state_next = dec_err ? RESP : WAIT;
        end
      end
      WAIT: begin
        // A ready arriving on the last allowed cycle still counts as success.
        if (sel_ready) begin
          done_ok    = 1'b1;
          state_next = RESP;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          timed_out  = 1'b1;
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= '0;
      sel_q     <= '0;
      err_q     <= 1'b0;
      cnt       <= '0;
      cpu_rdata <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        we_q    <= cpu_we;
        sel_q   <= dec_sel;
        err_q   <= dec_err;
        cnt     <= '0;
        if (dec_err) cpu_rdata <= ERR_DATA;
      end
      if (state == WAIT) cnt <= cnt + 1'b1;
      if (done_ok && (we_q == '0)) cpu_rdata <= sel_rdata;
      if (timed_out) begin
        err_q     <= 1'b1;
        cpu_rdata <= ERR_DATA;
      end
    end
  end

  assign cpu_ready = (state == RESP);
  assign cpu_err   = cpu_ready & err_q;
  assign per_ce    = (state == WAIT) ? sel_q : '0;
  assign per_we    = (state == WAIT) ? we_q : '0;
  assign per_addr  = {{(ADDR_W-REGION_BITS){1'b0}}, addr_q[REGION_BITS-1:0]};
  assign per_wdata = wdata_q;

`ifdef MMIO_ERR_LOG_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_addr  <= '0;
      err_count <= '0;
    end else if (cpu_err) begin
      err_addr <= addr_q;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`else
  // Upper address bits only feed the error log.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_q[ADDR_W-1:REGION_BITS];
`endif

endmodule

// File: tb/tb_mmio_interconnect.sv
// Randomized self-checking bench for mmio_interconnect against a transaction-level model.
// Error-log checks are included when MMIO_ERR_LOG_EN is defined.
module tb_mmio_interconnect;

  localparam int NS      = 4;
  localparam int DW      = 32;
  localparam int AW      = 32;
  localparam int TIMEOUT = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic            clk = 1'b0;
  logic            reset;
  logic            cpu_valid;
  logic [AW-1:0]   cpu_addr;
  logic [DW-1:0]   cpu_wdata;
  logic [3:0]      cpu_we;
  logic [DW-1:0]   cpu_rdata;
  logic            cpu_ready;
  logic            cpu_err;
  logic [NS-1:0]   per_ce;
  logic [AW-1:0]   per_addr;
  logic [DW-1:0]   per_wdata;
  logic [3:0]      per_we;
  logic [NS*DW-1:0] per_rdata;
  logic [NS-1:0]   per_ready;
`ifdef MMIO_ERR_LOG_EN
  logic [AW-1:0]   err_addr;
  logic [7:0]      err_count;
`endif

  int              tests_run = 0;
  int              tests_failed = 0;
  logic [31:0]     slave_data [NS];
  logic [31:0]     model_rdata = 32'h0;
  int              model_err_count = 0;
  logic [31:0]     model_err_addr = 32'h0;
  bit              pin_en = 1'b0;
  logic [31:0]     pin_data = 32'h0;

  mmio_interconnect dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_valid (cpu_valid),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_rdata (cpu_rdata),
    .cpu_ready (cpu_ready),
    .cpu_err   (cpu_err),
    .per_ce    (per_ce),
    .per_addr  (per_addr),
    .per_wdata (per_wdata),
    .per_we    (per_we),
    .per_rdata (per_rdata),
    .per_ready (per_ready)
`ifdef MMIO_ERR_LOG_EN
    ,
    .err_addr  (err_addr),
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One CPU transaction; slave ready comes in the (lat+1)-th cycle it is selected.
  // from_resp: called while the previous transaction is in its ready cycle.
  // keep_valid: leave the bus in the ready cycle so the next call chains back-to-back.
  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] we,
                               input logic [31:0] wdata, input int lat,
                               input bit from_resp, input bit keep_valid);
    logic [3:0]  idx4;
    int          off, exp_at, exp_ce, ready_at, ce_count, gate_errs;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [3:0]  ce_snap, we_snap;
    logic [31:0] addr_snap, wdata_snap;
    bit          drop_early;

    idx4 = addr[15:12];
    off  = from_resp ? 1 : 0;
    for (int s = 0; s < NS; s++) slave_data[s] = $urandom;
    if (pin_en && idx4 < NS) slave_data[idx4[1:0]] = pin_data;
    for (int s = 0; s < NS; s++) per_rdata[s*DW +: DW] = slave_data[s];

    if (idx4 >= NS) begin
      exp_err = 1'b1; exp_rd = ERR_DATA; exp_at = 1; exp_ce = 0;
    end else if (lat < TIMEOUT) begin
      exp_err = 1'b0;
      exp_rd  = (we == 4'b0) ? slave_data[idx4[1:0]] : model_rdata;
      exp_at  = lat + 2;
      exp_ce  = lat + 1;
    end else begin
      exp_err = 1'b1; exp_rd = ERR_DATA; exp_at = TIMEOUT + 1; exp_ce = TIMEOUT;
    end
    exp_at = exp_at + off;
    model_rdata = exp_rd;
    if (exp_err) begin
      if (model_err_count < 255) model_err_count++;
      model_err_addr = addr;
    end

    cpu_valid = 1'b1; cpu_addr = addr; cpu_we = we; cpu_wdata = wdata;
    drop_early = ($urandom_range(0, 1) == 1);
    ready_at = 0; ce_count = 0; gate_errs = 0;
    ce_snap = '0; we_snap = '0; addr_snap = '0; wdata_snap = '0;

    for (int j = 1; j <= TIMEOUT + 6; j++) begin
      @(posedge clk); #1;
      if (cpu_ready) begin
        ready_at = j;
        break;
      end
      if (per_ce != '0) begin
        ce_count++;
        if (ce_count == 1) begin
          ce_snap = per_ce; we_snap = per_we; addr_snap = per_addr; wdata_snap = per_wdata;
        end
      end else if (per_we != '0) begin
        gate_errs++;
      end
      if (drop_early && j == 1 + off) cpu_valid = 1'b0;
      per_ready = 4'($urandom);
      if (idx4 < NS) per_ready[idx4[1:0]] = per_ce[idx4[1:0]] && (ce_count > lat);
    end

    checkOutput("ready_latency", ready_at, exp_at);
    checkOutput("cpu_err", cpu_err, exp_err);
    checkOutput("cpu_rdata", cpu_rdata, exp_rd);
    checkOutput("ce_cycles", ce_count, exp_ce);
    checkOutput("we_gating", gate_errs, 0);
    if (exp_ce > 0) begin
      checkOutput("per_ce", ce_snap, 4'b0001 << idx4);
      checkOutput("per_we", we_snap, we);
      checkOutput("per_addr", addr_snap, {20'h0, addr[11:0]});
      checkOutput("per_wdata", wdata_snap, wdata);
    end
`ifdef MMIO_ERR_LOG_EN
    if (ready_at != 0) begin
      @(negedge clk);
      checkOutput("err_count", err_count, model_err_count);
      checkOutput("err_addr", err_addr, model_err_addr);
    end
`endif
    if (!keep_valid) begin
      if (ready_at != 0) begin
        cpu_valid = 1'b0;
        per_ready = '0;
        @(posedge clk); #1;
        checkOutput("ready_pulse", cpu_ready, 1'b0);
      end else begin
        cpu_valid = 1'b0;
        per_ready = '0;
        repeat (TIMEOUT + 4) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    int          lat;
    bit          keep, prev_keep;
    int          pulses;

    reset = 1'b0; cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_we = '0;
    per_rdata = '0; per_ready = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", cpu_ready, 1'b0);
    checkOutput("reset_err", cpu_err, 1'b0);
    checkOutput("reset_rdata", cpu_rdata, 32'h0);
    checkOutput("reset_ce", per_ce, 4'h0);
    checkOutput("reset_we", per_we, 4'h0);
    checkOutput("reset_addr", per_addr, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Read slave1, zero-wait
    pin_en = 1'b1; pin_data = 32'h1234_5678;
    applyStimulus(32'h0000_1010, 4'b0000, 32'h0, 0, 1'b0, 1'b0);
    pin_en = 1'b0;
    checkOutput("t1_rdata", cpu_rdata, 32'h1234_5678);

    // Write slave2 with waits; rdata must be left alone
    applyStimulus(32'h0000_2044, 4'b0011, 32'hAABB_CCDD, 3, 1'b0, 1'b0);
    checkOutput("t2_rdata_kept", cpu_rdata, 32'h1234_5678);

    // Decode error
    applyStimulus(32'h0000_5000, 4'b0000, 32'h0, 0, 1'b0, 1'b0);

    // Timeout, then last-cycle ready boundary
    applyStimulus(32'h0000_0100, 4'b0000, 32'h0, 100, 1'b0, 1'b0);
    applyStimulus(32'h0000_0104, 4'b0000, 32'h0, TIMEOUT - 1, 1'b0, 1'b0);
    applyStimulus(32'h0000_3108, 4'b1111, 32'h0102_0304, TIMEOUT, 1'b0, 1'b0);

    // Back-to-back slave0 then slave3
    applyStimulus(32'h0000_0004, 4'b0000, 32'h0, 0, 1'b0, 1'b1);
    applyStimulus(32'h0000_3008, 4'b0000, 32'h0, 0, 1'b1, 1'b0);

    // Reset in the middle of a WAIT
    cpu_valid = 1'b1; cpu_addr = 32'h0000_1020; cpu_we = 4'b0; per_ready = '0;
    @(posedge clk); #1;
    checkOutput("rst_ce_before", per_ce, 4'b0010);
    cpu_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_ce_after", per_ce, 4'h0);
    checkOutput("rst_ready", cpu_ready, 1'b0);
    checkOutput("rst_rdata", cpu_rdata, 32'h0);
    reset = 1'b1;
    pulses = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (cpu_ready) pulses++;
    end
    checkOutput("rst_no_ack", pulses, 0);
    model_rdata = 32'h0; model_err_count = 0; model_err_addr = 32'h0;
    applyStimulus(32'h0000_1030, 4'b0000, 32'h0, 1, 1'b0, 1'b0);

    // Randomized traffic
    prev_keep = 1'b0;
    for (int n = 0; n < 60; n++) begin
      a = {16'($urandom), 4'($urandom_range(0, 5)), 12'($urandom)};
      w = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'b0;
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 1)
                                        : $urandom_range(0, 5);
      keep = (n != 59) && ($urandom_range(0, 3) == 0);
      applyStimulus(a, w, 32'($urandom), lat, prev_keep, keep);
      prev_keep = keep;
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
